// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector with overlapping or non-overlapping
// detection and a registered one-cycle match pulse. SEQ_DET_MATCH_CNT_EN adds a saturating match counter.
module seq_detector_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
`ifdef SEQ_DET_MATCH_CNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             match
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;

    logic [PAT_W-1:0] history;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] hist_nxt;
    logic [LEN_W-1:0] fill_nxt;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] len_clamped;
    logic             hit;

    // Only the low cfg_len bits of the history take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++)
            len_mask[i] = (LEN_W'(i) < cfg_len);
    end

    always_comb begin
        hist_nxt = {history[PAT_W-2:0], din};
        fill_nxt = (fill >= MAX_LEN) ? MAX_LEN : fill + ONE;
        hit      = (fill_nxt >= cfg_len) && (((hist_nxt ^ cfg_pat) & len_mask) == '0);
    end

    always_comb begin
        len_clamped = pat_len;
        if (pat_len == '0)
            len_clamped = ONE;
        else if (pat_len > MAX_LEN)
            len_clamped = MAX_LEN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pat <= '0;
            cfg_len <= ONE;
            cfg_ovl <= 1'b1;
            history <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else if (cfg_load) begin
            // A config load restarts detection; the bit presented on this edge is dropped.
            cfg_pat <= pat;
            cfg_len <= len_clamped;
            cfg_ovl <= overlap;
            history <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else if (en) begin
            history <= hist_nxt;
            fill    <= (hit && !cfg_ovl) ? '0 : fill_nxt;
            match   <= hit;
        end else begin
            match   <= 1'b0;
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    // Counter is cleared only by reset, so it spans config reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            match_cnt <= '0;
        else if (!cfg_load && en && hit && (match_cnt != '1))
            match_cnt <= match_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomized self-checking bench for seq_detector_param against a bit-queue reference model.
// Runs with a 2-bit counter so saturation is exercised whenever SEQ_DET_MATCH_CNT_EN is defined.
module tb_seq_detector_param;

    localparam int PAT_W  = 8;
    localparam int LEN_W  = $clog2(PAT_W + 1);
    localparam int CNT_W  = 2;
    localparam int CNT_MX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en, din, cfg_load, overlap;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] pat_len;
    logic             match;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    int checks = 0;
    int errs   = 0;

    // Reference model: the accepted bits since the last restart, oldest first.
    bit             q[$];
    logic [PAT_W-1:0] m_pat;
    int             m_len;
    bit             m_ovl;
    int             m_cnt;
    bit             exp_match;

    seq_detector_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .din      (din),
        .cfg_load (cfg_load),
        .pat      (pat),
        .pat_len  (pat_len),
        .overlap  (overlap),
`ifdef SEQ_DET_MATCH_CNT_EN
        .match_cnt(match_cnt),
`endif
        .match    (match)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pat     = '0;
        m_len     = 1;
        m_ovl     = 1'b1;
        m_cnt     = 0;
        exp_match = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit d, input bit ld,
                              input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input bit o);
        bit hit;
        exp_match = 1'b0;
        if (ld) begin
            m_pat = p;
            m_len = (l == 0) ? 1 : ((int'(l) > PAT_W) ? PAT_W : int'(l));
            m_ovl = o;
            q.delete();
        end else if (e) begin
            q.push_back(d);
            if (q.size() > PAT_W) void'(q.pop_front());
            hit = (q.size() >= m_len);
            if (hit)
                for (int k = 0; k < m_len; k++)
                    if (q[q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
            if (hit) begin
                exp_match = 1'b1;
                if (m_cnt < CNT_MX) m_cnt++;
                if (!m_ovl) q.delete();
            end
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later.
    task automatic step(input bit e, input bit d, input bit ld,
                        input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input bit o);
        en = e; din = d; cfg_load = ld; pat = p; pat_len = l; overlap = o;
        @(posedge clk);
        model_step(e, d, ld, p, l, o);
        #1;
        chk("match", match, exp_match);
`ifdef SEQ_DET_MATCH_CNT_EN
        chk("match_cnt", match_cnt, m_cnt);
`endif
    endtask

    // Config inputs carry noise when cfg_load is low to show they are ignored.
    task automatic bit_in(input bit d);
        step(1'b1, d, 1'b0, PAT_W'($urandom), LEN_W'($urandom), $urandom_range(0, 1));
    endtask

    task automatic idle();
        step(1'b0, $urandom_range(0, 1), 1'b0, PAT_W'($urandom), LEN_W'($urandom), 1'b0);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input bit o);
        step(1'b0, 1'b0, 1'b1, p, l, o);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_match", match, 1'b0);
`ifdef SEQ_DET_MATCH_CNT_EN
        chk("rst_cnt", match_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit s1011[7];
        s1011 = '{1, 0, 1, 1, 0, 1, 1};
        en = 0; din = 0; cfg_load = 0; pat = '0; pat_len = '0; overlap = 1'b0;
        rst_n = 1'b1;
        #3;
        do_reset();

        // Overlapping 1011: matches after bits 4 and 7.
        load(8'b0000_1011, 4, 1'b1);
        foreach (s1011[i]) bit_in(s1011[i]);
        // Non-overlapping: only bit 4 matches.
        load(8'b0000_1011, 4, 1'b0);
        foreach (s1011[i]) bit_in(s1011[i]);

        // Gaps of 3 idle cycles between bits never break the pattern.
        load(8'b0000_1011, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bit_in(s1011[i]);
            repeat (3) idle();
        end

        // Load concurrent with a valid bit: the bit is dropped.
        bit_in(1); bit_in(0); bit_in(1);
        step(1'b1, 1'b1, 1'b1, 8'b11, 2, 1'b1);
        bit_in(1); bit_in(1); bit_in(1);

        // Mid-stream reset: progress lost, config back to len=1 pat=0.
        load(8'b0000_1011, 4, 1'b1);
        bit_in(1); bit_in(0); bit_in(1);
        do_reset();
        bit_in(1);
        bit_in(0);

        // Length clamps.
        load(8'h01, 0, 1'b1);
        bit_in(1); bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        load(8'hA5, 15, 1'b1);
        for (int i = PAT_W - 1; i >= 0; i--) bit_in(pat_bit(8'hA5, i));
        for (int i = PAT_W - 1; i >= 0; i--) bit_in(pat_bit(8'hA5, i));

        // Random traffic, biased toward short patterns so matches are frequent.
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                @(negedge clk);
                do_reset();
            end else if (r < 40)
                load(PAT_W'($urandom),
                     ($urandom_range(0, 3) == 0) ? LEN_W'($urandom) : LEN_W'($urandom_range(1, 4)),
                     $urandom_range(0, 1));
            else if (r < 700)
                bit_in($urandom_range(0, 1));
            else
                idle();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    function automatic bit pat_bit(input logic [PAT_W-1:0] p, input int i);
        return p[i];
    endfunction

endmodule
